path_query_sched: RTL and testbench
===================================

# path_query_sched

Multi-requester scheduler for the shared 3x3 grid shortest-path solver. It accepts path queries from N requesters and arbitrates between them round-robin. It validates each query, then drives the single combinational solver and holds the inputs stable for a fixed settle window. It captures the result and returns it on one shared response channel tagged with the requester ID.

## Interface
- N, 2, number of requesters (legal 2..4)
- SETTLE, 2, cycles solver inputs are held before result capture (legal 1..15)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N  per-requester query valid
- req_ready  out  N  per-requester accept; at most one bit high
- req_grid  in  N*9  per-requester grid, slice i = [9i+8:9i]; 1 = reachable; node k ↔ bit 9-k (node 1 = bit 8)
- req_start  in  N*4  per-requester start node, slice i = [4i+3:4i]
- req_end  in  N*4  per-requester end node
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  max(1,$clog2(N))  requester index of response
- resp_found  out  1  path found
- resp_len  out  4  shortest path length
- resp_path  out  9  path matrix
- resp_err  out  1  query rejected without solving
- slv_grid  out  9  solver grid input
- slv_start  out  4  solver start node
- slv_end  out  4  solver end node
- slv_found  in  1  solver path-found result
- slv_len  in  4  solver path length
- slv_path  in  9  solver path matrix

## Operation
- FSM states: IDLE, SOLVE, RESP.
- IDLE:
  - Arbiter grants the first requester with req_valid=1, searching from pointer ptr upward with wrap.
  - req_ready[grant]=1 for that requester only; req_ready is 0 in every other state.
  - On handshake, register grid/start/end/id and set ptr = grant+1 mod N.
- Validation at acceptance: the query is an error if start or end lies outside 1..9, or if the grid bit of start or end is 0.
  - Error → RESP with resp_err=1, resp_found=0, resp_len=0, resp_path=0. The solver is not used and slv_* keep their previous values.
  - Valid → SOLVE.
- SOLVE:
  - slv_* driven from the registered query.
  - Down-counter loaded with SETTLE-1 on entry and decremented each cycle.
  - At count 0, capture slv_found/slv_len/slv_path into the response registers and go to RESP with resp_err=0.
- RESP:
  - resp_valid=1. All resp_* outputs stay stable until resp_ready=1.
  - On handshake → IDLE.
- start == end is not special-cased; it is forwarded to the solver.
- Arithmetic: counter width 4 bits. Node range compare is unsigned on 4 bits, so 0 and 10..15 are errors.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_id=0, resp_found=0, resp_len=0, resp_path=0, resp_err=0, slv_grid=0, slv_start=0, slv_end=0. State IDLE, ptr=0.
- Accept edge = cycle 0. slv_* are valid from cycle 1. Valid query: resp_valid rises in cycle SETTLE+1.
- Error query: resp_valid rises in cycle 1.
- No bypass: the earliest next acceptance is the cycle after the response handshake. Peak throughput is one query per SETTLE+2 cycles.
- Response with resp_ready already high: handshake happens in the first RESP cycle, so resp_valid is high for exactly one cycle.
- req_valid deasserted before grant: no effect. The requester is not remembered.
- Simultaneous valids from all requesters: served strictly in rotation starting at ptr.
- rst during SOLVE or RESP: the in-flight query is dropped, no response is issued, and all outputs return to their reset values on the next edge.

## Structure
- Shared package path_ctrl_pkg holds:
  - state enum {IDLE, SOLVE, RESP}
  - constants GRID_W=9, NODE_W=4, LEN_W=4, NODE_MIN=1, NODE_MAX=9
  - function node_bit(grid, k) returning grid[9-k]
- Sub-module rr_arbiter (parameter N):
  - inputs req[N], ptr, en
  - output one-hot grant[N] and grant index
  - purely combinational; ptr register lives in path_query_sched
- The solver is external and connected through the slv_* ports.

## Test plan
- N=2, SETTLE=2. Req0: grid=9'h1FF, start=1, end=9. Solver model returns found=1, len=4, path=9'h1C7 → resp_valid in cycle 3 with id=0, err=0, len=4, path=9'h1C7.
- Req0 start=1 with grid=9'b000111111 → resp_valid in cycle 1 with err=1, found=0, len=0, path=0; slv_* unchanged.
- Req1 end=0, then a separate query with end=12 → both give err=1.
- Both requesters continuously valid, 4 queries, resp_ready=1 → grant order 0,1,0,1; req_ready never has two bits high.
- resp_ready held 0 for 5 cycles during RESP → resp_* stable, req_ready=0 throughout; acceptance only after the handshake.
- rst pulsed in the second SOLVE cycle → no response; outputs zero; the next query is granted starting at ptr=0.

Source files
------------

// File: rtl/path_ctrl_pkg.sv
// path_ctrl_pkg
//   Shared types, widths and helpers for the grid path-query scheduler.
//   state_t  : scheduler FSM states (IDLE, SOLVE, RESP)
//   query_t  : one path query (grid, start node, end node)
//   node_bit : reachability bit of node k (node 1 = grid bit 8)
//   query_ok : acceptance-time validation of a query
package path_ctrl_pkg;

    localparam int GRID_W = 9;
    localparam int NODE_W = 4;
    localparam int LEN_W  = 4;
    localparam logic [NODE_W-1:0] NODE_MIN = 4'd1;
    localparam logic [NODE_W-1:0] NODE_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SOLVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [GRID_W-1:0] grid;
        logic [NODE_W-1:0] start;
        logic [NODE_W-1:0] end_node;
    } query_t;

    // Node k maps to grid bit 9-k. Out-of-range nodes read as unreachable so
    // callers never index past the grid.
    function automatic logic node_bit(logic [GRID_W-1:0] grid, logic [NODE_W-1:0] k);
        logic [NODE_W-1:0] idx;
        idx = NODE_W'(GRID_W) - k;
        if (k < NODE_MIN || k > NODE_MAX)
            return 1'b0;
        return grid[idx];
    endfunction

    // A query is solvable only if both endpoints are real nodes and reachable.
    function automatic logic query_ok(query_t q);
        return node_bit(q.grid, q.start) && node_bit(q.grid, q.end_node);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. Grants the first asserted request at
//   or after ptr, wrapping modulo N. The pointer register is owned by the
//   caller.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   en        : arbitration enable; all grants are 0 when low
//   grant     : one-hot grant
//   grant_idx : index of the granted requester
//   grant_vld : a grant was issued
module rr_arbiter #(
    parameter  int N   = 2,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           grant_vld
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (en && !grant_vld && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
                grant_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/path_query_sched.sv
// path_query_sched
//   Accepts grid path queries from N requesters (round-robin), validates
//   them, drives the shared combinational solver for SETTLE cycles, captures
//   its result and returns it on one response channel tagged by requester.
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : per-requester handshake (ready one-hot)
//   req_grid/req_start/req_end    : per-requester query, packed by index
//   resp_valid/resp_ready         : response handshake
//   resp_id/found/len/path/err    : response payload, stable while valid
//   slv_grid/slv_start/slv_end    : solver inputs (held between queries)
//   slv_found/slv_len/slv_path    : solver outputs
module path_query_sched
    import path_ctrl_pkg::*;
#(
    parameter  int N      = 2,
    parameter  int SETTLE = 2,
    localparam int IDW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req_valid,
    output logic [N-1:0]        req_ready,
    input  logic [N*GRID_W-1:0] req_grid,
    input  logic [N*NODE_W-1:0] req_start,
    input  logic [N*NODE_W-1:0] req_end,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic                resp_found,
    output logic [LEN_W-1:0]    resp_len,
    output logic [GRID_W-1:0]   resp_path,
    output logic                resp_err,
    output logic [GRID_W-1:0]   slv_grid,
    output logic [NODE_W-1:0]   slv_start,
    output logic [NODE_W-1:0]   slv_end,
    input  logic                slv_found,
    input  logic [LEN_W-1:0]    slv_len,
    input  logic [GRID_W-1:0]   slv_path
);

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   q_id;
    logic [3:0]       cnt;

    query_t [N-1:0]   rq;
    query_t           sel_q;
    logic [IDW-1:0]   grant_idx;
    logic             grant_vld;
    logic             arb_en;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rq[i].grid     = req_grid[GRID_W*i +: GRID_W];
            rq[i].start    = req_start[NODE_W*i +: NODE_W];
            rq[i].end_node = req_end[NODE_W*i +: NODE_W];
        end
    end

    // Grants only in IDLE, and never while reset is asserted, so req_ready
    // reads 0 through reset regardless of req_valid.
    assign arb_en = (state == IDLE) && !rst;

    rr_arbiter #(.N(N)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .en        (arb_en),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign sel_q = rq[grant_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            q_id       <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_found <= 1'b0;
            resp_len   <= '0;
            resp_path  <= '0;
            resp_err   <= 1'b0;
            slv_grid   <= '0;
            slv_start  <= '0;
            slv_end    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // grant_vld already implies req_valid & req_ready.
                    if (grant_vld) begin
                        q_id <= grant_idx;
                        ptr  <= IDW'((int'(grant_idx) + 1) % N);
                        if (query_ok(sel_q)) begin
                            slv_grid  <= sel_q.grid;
                            slv_start <= sel_q.start;
                            slv_end   <= sel_q.end_node;
                            cnt       <= 4'(SETTLE - 1);
                            state     <= SOLVE;
                        end else begin
                            // Rejected: respond directly, solver inputs untouched.
                            resp_id    <= grant_idx;
                            resp_err   <= 1'b1;
                            resp_found <= 1'b0;
                            resp_len   <= '0;
                            resp_path  <= '0;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end
                end
                SOLVE: begin
                    if (cnt == 4'd0) begin
                        resp_id    <= q_id;
                        resp_err   <= 1'b0;
                        resp_found <= slv_found;
                        resp_len   <= slv_len;
                        resp_path  <= slv_path;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_path_query_sched.sv
module tb_path_query_sched;
    localparam int N      = 2;
    localparam int SETTLE = 2;
    localparam int IDW    = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*9-1:0]  req_grid;
    logic [N*4-1:0]  req_start;
    logic [N*4-1:0]  req_end;
    logic            resp_valid;
    logic            resp_ready;
    logic [IDW-1:0]  resp_id;
    logic            resp_found;
    logic [3:0]      resp_len;
    logic [8:0]      resp_path;
    logic            resp_err;
    logic [8:0]      slv_grid;
    logic [3:0]      slv_start;
    logic [3:0]      slv_end;
    logic            slv_found;
    logic [3:0]      slv_len;
    logic [8:0]      slv_path;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    path_query_sched #(.N(N), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_grid(req_grid), .req_start(req_start), .req_end(req_end),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_found(resp_found), .resp_len(resp_len), .resp_path(resp_path),
        .resp_err(resp_err),
        .slv_grid(slv_grid), .slv_start(slv_start), .slv_end(slv_end),
        .slv_found(slv_found), .slv_len(slv_len), .slv_path(slv_path)
    );

    // Stand-in solver: the test-plan query gets its documented answer, every
    // other input gets a deterministic scramble so captures are traceable.
    function automatic logic [13:0] solve_model(logic [8:0] g, logic [3:0] s, logic [3:0] e);
        if (g == 9'h1FF && s == 4'd1 && e == 4'd9)
            return {1'b1, 4'd4, 9'h1C7};
        return {^{g, s, e}, 4'(s + e), g ^ {e[0], s, e}};
    endfunction

    assign {slv_found, slv_len, slv_path} = solve_model(slv_grid, slv_start, slv_end);

    function automatic bit reachable(logic [8:0] g, logic [3:0] k);
        if (k < 4'd1 || k > 4'd9) return 1'b0;
        return g[9 - int'(k)];
    endfunction

    function automatic bit is_err(logic [8:0] g, logic [3:0] s, logic [3:0] e);
        return !(reachable(g, s) && reachable(g, e));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_req(int id, logic [8:0] g, logic [3:0] s, logic [3:0] e);
        req_grid[9*id +: 9]  = g;
        req_start[4*id +: 4] = s;
        req_end[4*id +: 4]   = e;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One query from requester id with resp_ready held high. lat is the cycle
    // (accept edge = 0) in which resp_valid is first seen; -1 on timeout.
    task automatic run_query(input int id, input logic [8:0] g, input logic [3:0] s,
                             input logic [3:0] e, output int lat, output logic [13:0] res,
                             output logic rerr, output logic [IDW-1:0] rid,
                             output logic [16:0] slv_c1);
        bit ok;
        @(posedge clk); #1;
        set_req(id, g, s, e);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        resp_ready    = 1'b1;
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin ok = 1; break; end
        end
        chk("accept_timeout", 32'(ok), 1);
        @(posedge clk); #1 req_valid = '0;
        lat = -1; res = '0; rerr = 1'b0; rid = '0; slv_c1 = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) slv_c1 = {slv_grid, slv_start, slv_end};
            if (resp_valid) begin
                lat  = c;
                res  = {resp_found, resp_len, resp_path};
                rerr = resp_err;
                rid  = resp_id;
                break;
            end
        end
    endtask

    typedef struct {
        int         id;
        logic [8:0] grid;
        logic [3:0] s;
        logic [3:0] e;
        bit         err;
        int         lat;
    } vec_t;

    typedef struct {
        int          id;
        bit          err;
        logic [13:0] res;
        int          acc;
    } exp_t;

    initial begin
        vec_t        vt[8];
        exp_t        eq[$];
        exp_t        ex;
        int          lat, n, m_ptr, g, nresp;
        bit          rv_seen;
        logic [13:0] res, snap_res;
        logic        rerr;
        logic [IDW-1:0] rid;
        logic [16:0] slv_c1, slv_before;
        int          order[4];

        req_grid = '0; req_start = '0; req_end = '0;
        do_reset();
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_resp_valid", 32'(resp_valid), 0);
        chk("reset_resp_bus", {resp_id, resp_found, resp_len, resp_path, resp_err}, 0);
        chk("reset_slv_bus", {slv_grid, slv_start, slv_end}, 0);

        // ---------------- table-driven single queries ----------------
        vt[0] = '{0, 9'h1FF,       4'd1, 4'd9,  1'b0, SETTLE + 1};
        vt[1] = '{0, 9'b000111111, 4'd1, 4'd9,  1'b1, 1};
        vt[2] = '{1, 9'h1FF,       4'd1, 4'd0,  1'b1, 1};
        vt[3] = '{1, 9'h1FF,       4'd1, 4'd12, 1'b1, 1};
        vt[4] = '{1, 9'h0F5,       4'd3, 4'd3,  1'b0, SETTLE + 1};
        vt[5] = '{0, 9'h1FE,       4'd2, 4'd9,  1'b1, 1};
        vt[6] = '{0, 9'h1FF,       4'd0, 4'd5,  1'b1, 1};
        vt[7] = '{1, 9'h155,       4'd1, 4'd9,  1'b0, SETTLE + 1};
        for (int i = 0; i < 8; i++) begin
            slv_before = {slv_grid, slv_start, slv_end};
            run_query(vt[i].id, vt[i].grid, vt[i].s, vt[i].e, lat, res, rerr, rid, slv_c1);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d_err", i), 32'(rerr), 32'(vt[i].err));
            chk($sformatf("vec%0d_id", i), 32'(rid), 32'(vt[i].id));
            chk($sformatf("vec%0d_result", i), 32'(res),
                vt[i].err ? 32'd0 : 32'(solve_model(vt[i].grid, vt[i].s, vt[i].e)));
            chk($sformatf("vec%0d_slv", i), 32'(slv_c1),
                vt[i].err ? 32'(slv_before) : 32'({vt[i].grid, vt[i].s, vt[i].e}));
        end
        @(posedge clk); #1;

        // ---------------- rotation with both requesters always valid ----------------
        do_reset();
        set_req(0, 9'h1FF, 4'd1, 4'd9);
        set_req(1, 9'h1FF, 4'd1, 4'd9);
        resp_ready = 1'b1;
        req_valid  = 2'b11;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
            if (req_ready != '0) begin
                order[n] = req_ready[1] ? 1 : 0;
                n++;
            end
        end
        chk("rotation_count", 32'(n), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("rotation_%0d", i), 32'(order[i]), 32'(i % 2));
        @(posedge clk); #1 req_valid = '0;
        repeat (SETTLE + 3) @(posedge clk);
        #1;

        // ---------------- backpressure in RESP ----------------
        // ptr is back at 0 after the 0,1,0,1 rotation.
        resp_ready = 1'b0;
        req_valid  = 2'b01;
        n = 0;
        for (int c = 0; c < 20 && n == 0; c++) begin
            @(negedge clk);
            if (req_ready[0]) n = 1;
        end
        chk("bp_accept", 32'(n), 1);
        @(posedge clk); #1 req_valid = 2'b11;
        n = 0;
        for (int c = 0; c < 20 && n == 0; c++) begin
            @(negedge clk);
            if (resp_valid) n = 1;
        end
        chk("bp_resp_seen", 32'(n), 1);
        snap_res = {resp_found, resp_len, resp_path};
        chk("bp_result", 32'(snap_res), 32'(solve_model(9'h1FF, 4'd1, 4'd9)));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_stable", {resp_valid, resp_id, resp_err, resp_found, resp_len, resp_path},
                {1'b1, 1'b0, 1'b0, snap_res});
            chk("bp_no_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_cycle_ready", 32'(req_ready), 0);
        chk("bp_hs_cycle_valid", 32'(resp_valid), 1);
        @(negedge clk);
        chk("bp_after_hs_valid", 32'(resp_valid), 0);
        chk("bp_after_hs_grant", 32'(req_ready), 32'b10);
        req_valid = '0;
        @(posedge clk); #1;

        // ---------------- reset in the second SOLVE cycle ----------------
        do_reset();
        set_req(0, 9'h1FF, 4'd1, 4'd9);
        set_req(1, 9'h1FF, 4'd1, 4'd9);
        resp_ready = 1'b1;
        req_valid  = 2'b01;
        n = 0;
        for (int c = 0; c < 20 && n == 0; c++) begin
            @(negedge clk);
            if (req_ready[0]) n = 1;
        end
        chk("rst_accept", 32'(n), 1);
        @(posedge clk); #1 req_valid = '0;   // now cycle 1
        @(posedge clk); #1 rst = 1'b1;       // now cycle 2
        @(posedge clk); #1;
        chk("rst_resp_bus", {resp_valid, resp_id, resp_found, resp_len, resp_path, resp_err}, 0);
        chk("rst_slv_bus", {slv_grid, slv_start, slv_end}, 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        chk("rst_no_resp", 32'(n), 0);
        @(posedge clk); #1 req_valid = 2'b11;
        @(negedge clk);
        chk("rst_ptr_zero", 32'(req_ready), 32'b01);
        req_valid = '0;
        @(posedge clk); #1;

        // ---------------- randomized traffic vs. reference model ----------------
        do_reset();
        m_ptr = 0; nresp = 0; rv_seen = 0;
        for (int c = 0; c < 4000 && nresp < 60; c++) begin
            @(posedge clk); #1;
            req_valid = N'($urandom_range(0, 3));
            for (int i = 0; i < N; i++)
                set_req(i, ($urandom_range(0, 1) != 0) ? 9'h1FF : 9'($urandom),
                        4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)));
            resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (req_ready != '0) begin
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                chk("rr_grant", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
                if (g >= 0) begin
                    ex.id  = g;
                    ex.err = is_err(req_grid[9*g +: 9], req_start[4*g +: 4], req_end[4*g +: 4]);
                    ex.res = ex.err ? 14'd0 :
                             solve_model(req_grid[9*g +: 9], req_start[4*g +: 4], req_end[4*g +: 4]);
                    ex.acc = cyc;
                    eq.push_back(ex);
                    m_ptr = (g + 1) % N;
                end
            end
            if (resp_valid) begin
                if (eq.size() == 0) begin
                    chk("rand_unexpected_resp", 32'(resp_valid), 0);
                end else begin
                    ex = eq[0];
                    if (!rv_seen) begin
                        rv_seen = 1;
                        chk("rand_latency", 32'(cyc - ex.acc), ex.err ? 32'd1 : 32'(SETTLE + 1));
                    end
                    chk("rand_id", 32'(resp_id), 32'(ex.id));
                    chk("rand_err", 32'(resp_err), 32'(ex.err));
                    chk("rand_result", 32'({resp_found, resp_len, resp_path}), 32'(ex.res));
                    if (resp_ready) begin
                        void'(eq.pop_front());
                        rv_seen = 0;
                        nresp++;
                    end
                end
            end
        end
        chk("rand_resp_count", 32'(nresp >= 60), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
